// File: rtl/parking_gate_if.sv
// Gate controller signal bundle.
// Groups the sensors, badge readers and admission flags (driven towards the
// controller) with the barrier, lamp and event strobe outputs (driven by it).
//   master : side that drives sensors/badges/flags and observes controller outputs
//   slave  : the controller itself
interface parking_gate_if;
    logic entry_arrive;
    logic entry_pass;
    logic exit_arrive;
    logic exit_pass;
    logic entry_is_uni;
    logic exit_is_uni;
    logic uni_is_vacated_space;
    logic is_vacated_space;
    logic entry_gate_open;
    logic exit_gate_open;
    logic entry_deny;
    logic entry_abort;
    logic exit_abort;
    logic car_entered;
    logic car_exited;
    logic is_uni_car_entered;
    logic is_uni_car_exited;

    modport master (
        output entry_arrive, entry_pass, exit_arrive, exit_pass,
        output entry_is_uni, exit_is_uni, uni_is_vacated_space, is_vacated_space,
        input  entry_gate_open, exit_gate_open, entry_deny, entry_abort, exit_abort,
        input  car_entered, car_exited, is_uni_car_entered, is_uni_car_exited
    );

    modport slave (
        input  entry_arrive, entry_pass, exit_arrive, exit_pass,
        input  entry_is_uni, exit_is_uni, uni_is_vacated_space, is_vacated_space,
        output entry_gate_open, exit_gate_open, entry_deny, entry_abort, exit_abort,
        output car_entered, car_exited, is_uni_car_entered, is_uni_car_exited
    );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Parking lot gate controller.
// Two lane FSMs (index 0 = entry, 1 = exit) drive the barriers from
// synchronized loop sensors; a shared emitter serializes the active-low
// car_entered / car_exited strobes and their is_uni qualifiers.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : parking_gate_if slave (sensors, badges, flags in; gates, lamp, strobes out)
//
// Lane FSM
//   state     | meaning
//   L_IDLE    | waiting for arrive
//   L_CHECK   | one cycle: latch badge, decide admission
//   L_OPEN    | barrier open, timeout timer running
//   L_PASSING | car on pass loop, barrier open
//   L_POST    | barrier closed, event request pending until acknowledged
//   L_DENY    | entry only: lot full lamp until car leaves arrive loop
// Emitter FSM
//   state     | meaning
//   E_IDLE    | waiting for a request, exit lane has priority
//   E_SETUP   | one cycle, qualifier settles with both strobes high
//   E_PULSE   | selected strobe low for PULSE_LEN cycles
//   E_GAP     | both strobes high for GAP_LEN cycles
module parking_gate_ctrl #(
    parameter int OPEN_TIMEOUT = 1000,
    parameter int PULSE_LEN    = 4,
    parameter int GAP_LEN      = 2
) (
    input logic           clk,
    input logic           rst_n,
    parking_gate_if.slave bus
);
    localparam int TW = $clog2(OPEN_TIMEOUT + 1);
    localparam int CW = $clog2(((PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN) + 1);

    typedef enum logic [2:0] {
        L_IDLE, L_CHECK, L_OPEN, L_PASSING, L_POST, L_DENY
    } lane_state_t;

    typedef enum logic [1:0] {
        E_IDLE, E_SETUP, E_PULSE, E_GAP
    } emit_state_t;

    logic [3:0]    sync1_q, sync2_q;
    logic [1:0]    arrive_s, pass_s, badge, req, ack, abort;
    lane_state_t   lane_q [2];
    lane_state_t   lane_d [2];
    logic [TW-1:0] timer_q [2];
    logic [TW-1:0] timer_d [2];
    logic [1:0]    uni_q, uni_d;

    emit_state_t   emit_q, emit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_exit_q, sel_exit_d;
    logic          car_entered_q, car_entered_d, car_exited_q, car_exited_d;
    logic          qual_en_q, qual_en_d, qual_ex_q, qual_ex_d;

    assign arrive_s = {sync2_q[2], sync2_q[0]};
    assign pass_s   = {sync2_q[3], sync2_q[1]};
    assign badge    = {bus.exit_is_uni, bus.entry_is_uni};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus.exit_pass, bus.exit_arrive, bus.entry_pass, bus.entry_arrive};
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 2; l++) begin
                lane_q[l]  <= L_IDLE;
                timer_q[l] <= '0;
            end
            uni_q <= '0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                lane_q[l]  <= lane_d[l];
                timer_q[l] <= timer_d[l];
            end
            uni_q <= uni_d;
        end
    end

    // Kept separate from the lane process so req -> ack -> lane_d is not a loop.
    assign req[0] = (lane_q[0] == L_POST);
    assign req[1] = (lane_q[1] == L_POST);
    assign ack[1] = (emit_q == E_IDLE) && req[1];
    assign ack[0] = (emit_q == E_IDLE) && req[0] && !req[1];

    always_comb begin
        uni_d = uni_q;
        abort = '0;
        for (int l = 0; l < 2; l++) begin
            lane_d[l]  = lane_q[l];
            timer_d[l] = timer_q[l];
            case (lane_q[l])
                L_IDLE: if (arrive_s[l]) lane_d[l] = L_CHECK;
                L_CHECK: begin
                    uni_d[l]   = badge[l];
                    timer_d[l] = '0;
                    // Only the entry lane can refuse; the exit always opens.
                    if (l == 0 && !(badge[l] ? bus.uni_is_vacated_space : bus.is_vacated_space))
                        lane_d[l] = L_DENY;
                    else
                        lane_d[l] = L_OPEN;
                end
                L_OPEN: begin
                    if (pass_s[l]) begin
                        lane_d[l] = L_PASSING;
                    end else if (timer_q[l] == TW'(OPEN_TIMEOUT)) begin
                        abort[l]  = 1'b1;
                        lane_d[l] = L_IDLE;
                    end else begin
                        timer_d[l] = timer_q[l] + TW'(1);
                    end
                end
                L_PASSING: if (!pass_s[l]) lane_d[l] = L_POST;
                L_POST:    if (ack[l]) lane_d[l] = L_IDLE;
                L_DENY:    if (!arrive_s[l]) lane_d[l] = L_IDLE;
                default:   lane_d[l] = L_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            emit_q        <= E_IDLE;
            cnt_q         <= '0;
            sel_exit_q    <= 1'b0;
            car_entered_q <= 1'b1;
            car_exited_q  <= 1'b1;
            qual_en_q     <= 1'b0;
            qual_ex_q     <= 1'b0;
        end else begin
            emit_q        <= emit_d;
            cnt_q         <= cnt_d;
            sel_exit_q    <= sel_exit_d;
            car_entered_q <= car_entered_d;
            car_exited_q  <= car_exited_d;
            qual_en_q     <= qual_en_d;
            qual_ex_q     <= qual_ex_d;
        end
    end

    always_comb begin
        emit_d     = emit_q;
        cnt_d      = cnt_q;
        sel_exit_d = sel_exit_q;
        qual_en_d  = qual_en_q;
        qual_ex_d  = qual_ex_q;
        case (emit_q)
            E_IDLE: begin
                if (|req) begin
                    sel_exit_d = req[1];
                    if (req[1]) qual_ex_d = uni_q[1];
                    else        qual_en_d = uni_q[0];
                    emit_d = E_SETUP;
                end
            end
            E_SETUP: begin
                cnt_d  = '0;
                emit_d = E_PULSE;
            end
            E_PULSE: begin
                if (cnt_q == CW'(PULSE_LEN - 1)) begin
                    cnt_d  = '0;
                    emit_d = E_GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            E_GAP: begin
                if (cnt_q == CW'(GAP_LEN - 1)) begin
                    cnt_d  = '0;
                    emit_d = E_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: emit_d = E_IDLE;
        endcase
        // Strobes are registered from the next state so they are low exactly
        // while the emitter sits in E_PULSE, with no decode glitches.
        car_entered_d = !((emit_d == E_PULSE) && !sel_exit_d);
        car_exited_d  = !((emit_d == E_PULSE) && sel_exit_d);
    end

    assign bus.entry_gate_open    = (lane_q[0] == L_OPEN) || (lane_q[0] == L_PASSING);
    assign bus.exit_gate_open     = (lane_q[1] == L_OPEN) || (lane_q[1] == L_PASSING);
    assign bus.entry_deny         = (lane_q[0] == L_DENY);
    assign bus.entry_abort        = abort[0];
    assign bus.exit_abort         = abort[1];
    assign bus.car_entered        = car_entered_q;
    assign bus.car_exited         = car_exited_q;
    assign bus.is_uni_car_entered = qual_en_q;
    assign bus.is_uni_car_exited  = qual_ex_q;
endmodule
